// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding,
// default array geometry and the RUN-phase length helper.
package systolic_pkg;

  localparam int SYS_ARRAY_N   = 4;
  localparam int SYS_DATA_SIZE = 8;
  // RUN lasts nv + (2*N-1) cycles: N-1 of input skew plus N of drain.
  localparam int SYS_RUN_TAIL  = 2*SYS_ARRAY_N-1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  function automatic int run_tail(input int n);
    return 2*n-1;
  endfunction

endpackage

// File: rtl/systolic_window_mask.sv
// Combinational window masks for a skewed systolic array.
// Row r sees activation for t in [r, nv+r); column c presents a result
// for t in [c+N, nv+c+N), the extra N covering the registered PE chain.
module systolic_window_mask
  import systolic_pkg::*;
#(
  parameter int ARRAY_N = SYS_ARRAY_N,
  parameter int VEC_W   = 8,
  parameter int TW      = 11
) (
  input  logic [TW-1:0]      t,
  input  logic [VEC_W-1:0]   nv,
  output logic [ARRAY_N-1:0] row_en,
  output logic [ARRAY_N-1:0] col_en
);

  logic [TW-1:0] nvw;
  assign nvw = TW'(nv);

  for (genvar r = 0; r < ARRAY_N; r++) begin : g_lane
    localparam logic [TW-1:0] RO = TW'(r);
    localparam logic [TW-1:0] CO = TW'(r + ARRAY_N);
    // Row 0 opens at t=0, so only the upper bound matters there.
    if (r == 0) begin : g_row0
      assign row_en[r] = (t < nvw);
    end else begin : g_rowr
      assign row_en[r] = (t >= RO) && (t < nvw + RO);
    end
    assign col_en[r] = (t >= CO) && (t < nvw + CO);
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an ARRAY_N x ARRAY_N systolic MAC grid: weight load,
// skewed activation streaming, then partial-sum drain.
// Optional build macro SYSTOLIC_SEQ_CTRL_PERF_EN adds busy-cycle and
// job counters (perf_cycles, perf_jobs).
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_N = SYS_ARRAY_N,
  parameter int MAX_VEC = 255,
  parameter int VEC_W   = 8,
  parameter int ROW_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [VEC_W-1:0]   num_vec,
  output logic               busy,
  output logic               done,
  output logic               w_ld_en,
  output logic [ROW_W-1:0]   w_ld_row,
  output logic               act_rd_en,
  output logic [VEC_W-1:0]   act_rd_addr,
  output logic [ARRAY_N-1:0] row_en,
  output logic [ARRAY_N-1:0] res_col_en,
  output logic [VEC_W-1:0]   res_idx
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [15:0]        perf_jobs
`endif
);

  // One extra bit over VEC_W+ROW_W keeps nv+2N-2 from wrapping at MAX_VEC.
  localparam int            TW        = VEC_W + ROW_W + 1;
  localparam logic [TW-1:0] LOAD_LAST = TW'(ARRAY_N - 1);
  localparam logic [TW-1:0] RUN_LAST  = TW'(run_tail(ARRAY_N) - 1);
  localparam logic [TW-1:0] N_T       = TW'(ARRAY_N);

  seq_state_e         state, state_n;
  logic [TW-1:0]      t, t_n;
  logic [VEC_W-1:0]   nv, nv_n, nv_in;
  logic [ARRAY_N-1:0] row_m, col_m;
  logic               run_n, act_n;

  // Requests beyond MAX_VEC are clamped when the counter could hold them.
  if (MAX_VEC < (1 << VEC_W) - 1) begin : g_clamp
    localparam logic [VEC_W-1:0] MAX_NV = VEC_W'(MAX_VEC);
    assign nv_in = (num_vec > MAX_NV) ? MAX_NV : num_vec;
  end else begin : g_pass
    assign nv_in = num_vec;
  end

  // Next-state, next-t and job-length latch; t restarts on each state entry.
  always_comb begin
    state_n = state;
    t_n     = t + TW'(1);
    nv_n    = nv;
    case (state)
      IDLE: begin
        t_n = '0;
        if (start) begin
          if (nv_in != '0) begin
            state_n = LOAD_W;
            nv_n    = nv_in;
          end else begin
            state_n = DONE;
          end
        end
      end
      LOAD_W: begin
        if (t == LOAD_LAST) begin
          state_n = RUN;
          t_n     = '0;
        end
      end
      RUN: begin
        if (t == TW'(nv) + RUN_LAST) begin
          state_n = DONE;
          t_n     = '0;
        end
      end
      DONE: begin
        state_n = IDLE;
        t_n     = '0;
      end
      default: begin
        state_n = IDLE;
        t_n     = '0;
      end
    endcase
  end

  // Masks come from next-state t so the registered outputs line up with it.
  systolic_window_mask #(
    .ARRAY_N (ARRAY_N),
    .VEC_W   (VEC_W),
    .TW      (TW)
  ) u_mask (
    .t      (t_n),
    .nv     (nv_n),
    .row_en (row_m),
    .col_en (col_m)
  );

  assign run_n = (state_n == RUN);
  assign act_n = run_n && (t_n < TW'(nv_n));

  // State, cycle counter and latched vector count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      t     <= '0;
      nv    <= '0;
    end else begin
      state <= state_n;
      t     <= t_n;
      nv    <= nv_n;
    end
  end

  // Registered strobes, decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      w_ld_en     <= 1'b0;
      w_ld_row    <= '0;
      act_rd_en   <= 1'b0;
      act_rd_addr <= '0;
      row_en      <= '0;
      res_col_en  <= '0;
      res_idx     <= '0;
    end else begin
      busy        <= (state_n == LOAD_W) || run_n;
      done        <= (state_n == DONE);
      w_ld_en     <= (state_n == LOAD_W);
      w_ld_row    <= (state_n == LOAD_W) ? t_n[ROW_W-1:0] : '0;
      act_rd_en   <= act_n;
      act_rd_addr <= act_n ? t_n[VEC_W-1:0] : '0;
      row_en      <= run_n ? row_m : '0;
      res_col_en  <= run_n ? col_m : '0;
      if (run_n && col_m[0]) res_idx <= VEC_W'(t_n - N_T);
    end
  end

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  // Saturating busy-cycle and completed-job counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles <= '0;
      perf_jobs   <= '0;
    end else begin
      if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
      if (done && (perf_jobs != '1))   perf_jobs   <= perf_jobs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed and random jobs checked each cycle
// against a phase-level model of the sequencer timeline.
module tb_systolic_seq_ctrl;

  localparam int N  = 4;
  localparam int VW = 8;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [VW-1:0] num_vec = '0;
  logic          busy, done, w_ld_en, act_rd_en;
  logic [RW-1:0] w_ld_row;
  logic [VW-1:0] act_rd_addr, res_idx;
  logic [N-1:0]  row_en, res_col_en;
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_jobs;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [VW-1:0] m_res_idx = '0;

  systolic_seq_ctrl #(.ARRAY_N(N), .MAX_VEC(255), .VEC_W(VW), .ROW_W(RW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_vec     (num_vec),
    .busy        (busy),
    .done        (done),
    .w_ld_en     (w_ld_en),
    .w_ld_row    (w_ld_row),
    .act_rd_en   (act_rd_en),
    .act_rd_addr (act_rd_addr),
    .row_en      (row_en),
    .res_col_en  (res_col_en),
    .res_idx     (res_idx)
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_jobs   (perf_jobs)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int nv, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s nv=%0d k=%0d observed=%0h expected=%0h", tag, nv, k, obs, exp);
    end
  endtask

  // Expected outputs k cycles after the start-accept cycle of a job of nv
  // vectors: cycles 1..N load weights, then nv+2N-1 RUN cycles, then done.
  task automatic check_cycle(input int nv, input int k);
    logic          e_busy = 1'b0, e_done = 1'b0, e_wld = 1'b0, e_act = 1'b0;
    logic [RW-1:0] e_row = '0;
    logic [VW-1:0] e_addr = '0;
    logic [N-1:0]  e_ren = '0, e_cen = '0;
    int            len, t;
    len = (nv == 0) ? 1 : 1 + N + nv + 2*N - 1;
    if (nv == 0) begin
      e_done = (k == 1);
    end else if (k >= 1 && k <= N) begin
      e_busy = 1'b1; e_wld = 1'b1; e_row = RW'(k - 1);
    end else if (k > N && k < len) begin
      e_busy = 1'b1;
      t = k - N - 1;
      if (t < nv) begin e_act = 1'b1; e_addr = VW'(t); end
      for (int r = 0; r < N; r++) begin
        e_ren[r] = (t >= r) && (t < nv + r);
        e_cen[r] = (t >= r + N) && (t < nv + r + N);
      end
      if (e_cen[0]) m_res_idx = VW'(t - N);
    end else if (k == len) begin
      e_done = 1'b1;
    end
    chk("busy",        nv, k, 32'(busy),        32'(e_busy));
    chk("done",        nv, k, 32'(done),        32'(e_done));
    chk("w_ld_en",     nv, k, 32'(w_ld_en),     32'(e_wld));
    chk("w_ld_row",    nv, k, 32'(w_ld_row),    32'(e_row));
    chk("act_rd_en",   nv, k, 32'(act_rd_en),   32'(e_act));
    chk("act_rd_addr", nv, k, 32'(act_rd_addr), 32'(e_addr));
    chk("row_en",      nv, k, 32'(row_en),      32'(e_ren));
    chk("res_col_en",  nv, k, 32'(res_col_en),  32'(e_cen));
    chk("res_idx",     nv, k, 32'(res_idx),     32'(m_res_idx));
  endtask

  // Whole job from start pulse to two idle cycles past done; optionally
  // pulses start again at cycle inj_k with num_vec=inj_nv (must be ignored).
  task automatic run_job(input int nv, input int inj_k, input int inj_nv);
    int len;
    len = (nv == 0) ? 1 : 1 + N + nv + 2*N - 1;
    @(posedge clk); #1;
    start = 1'b1; num_vec = VW'(nv);
    for (int k = 1; k <= len + 2; k++) begin
      @(posedge clk); #1;
      start   = (k == inj_k);
      num_vec = (k == inj_k) ? VW'(inj_nv) : VW'($urandom);
      @(negedge clk);
      check_cycle(nv, k);
    end
    start = 1'b0;
  endtask

  initial begin
    // reset state
    @(posedge clk); #1;
    check_cycle(0, 100);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); check_cycle(0, 100);

    run_job(1, -1, 0);          // single vector, full timeline
    run_job(3, -1, 0);          // skew/drain windows
    run_job(0, -1, 0);          // zero-length job goes straight to done
    run_job(5, N + 3, 7);       // start during RUN ignored
    run_job(2, 2, 9);           // start during LOAD_W ignored
    for (int j = 0; j < 6; j++) run_job(int'($urandom_range(1, 20)), -1, 0);
    run_job(255, -1, 0);        // MAX_VEC: no wrap of address or result index

    // reset asserted in RUN at t=2 aborts the job asynchronously
    @(posedge clk); #1;
    start = 1'b1; num_vec = VW'(5);
    for (int k = 1; k <= N + 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_cycle(5, k);
    end
    #1 reset = 1'b0;
    m_res_idx = '0;
    #1 check_cycle(0, 200);
    @(posedge clk); #1 check_cycle(0, 201);
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check_cycle(0, 300 + k);
    end
    run_job(int'($urandom_range(1, 12)), -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
